// File: rtl/gate_response_checker.sv
// gate_response_checker: checks NAND/NOR/XNOR gate responses, counts vectors/errors, tracks coverage, issues a verdict
module gate_response_checker #(
  parameter int NUM_VECTORS = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             err_pulse,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       first_err_code
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;
  state_t state, state_nxt;
  logic sample, last, ab_x, clr;
  logic [2:0] bad;
  logic [3:0] cov_nxt;
  logic [CNT_W-1:0] err_nxt;
  // an unknown operand makes the whole vector bad and leaves coverage untouched
  always_comb begin
    ab_x = (^{a, b}) === 1'bx;
    bad = ab_x ? 3'b111 : {c !== ~(a & b), d !== ~(a | b), e !== ~(a ^ b)};
    sample = (state == RUN) && vld;
    last = sample && (vec_cnt == LAST_IDX);
    clr = start && (state != RUN);
    cov_nxt = cov | ((sample && !ab_x) ? 4'b0001 << {a, b} : 4'b0000);
    err_nxt = (sample && |bad && err_cnt != ERR_MAX) ? err_cnt + 1'b1 : err_cnt;
    state_nxt = clr ? RUN : last ? DONE : state;
  end
  // state, counters, first-error capture and verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pass <= 1'b0;
      vec_cnt <= '0;
      err_cnt <= '0;
      cov <= '0;
      err_pulse <= 1'b0;
      first_err_idx <= '0;
      first_err_code <= '0;
    end else begin
      state <= state_nxt;
      err_pulse <= sample && |bad;
      if (clr) begin
        pass <= 1'b0;
        vec_cnt <= '0;
        err_cnt <= '0;
        cov <= '0;
        first_err_idx <= '0;
        first_err_code <= '0;
      end else if (sample) begin
        vec_cnt <= vec_cnt + 1'b1;
        err_cnt <= err_nxt;
        cov <= cov_nxt;
        if (|bad && err_cnt == '0) begin
          first_err_idx <= vec_cnt;
          first_err_code <= bad;
        end
        if (last) pass <= (err_nxt == '0) && (cov_nxt == 4'hF);
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule
